// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, BTB entry layout and counter helpers.
// Combinational helpers only; no latency, no backpressure.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Sized for the smallest BTB (2 entries), so any legal depth fits.
  localparam int BTB_TAG_MAX_W = 29;
  localparam int BTB_CTR_MAX_W = 3;

  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_MAX_W-1:0] tag;
    word_t                    target;
    logic [BTB_CTR_MAX_W-1:0] counter;
  } btb_entry_t;

  function automatic logic [BTB_CTR_MAX_W-1:0] BTB_CTR_WEAK_T(input int ctr_bits);
    return BTB_CTR_MAX_W'(1 << (ctr_bits - 1));
  endfunction

  function automatic logic [BTB_CTR_MAX_W-1:0] BTB_CTR_WEAK_NT(input int ctr_bits);
    return BTB_CTR_MAX_W'((1 << (ctr_bits - 1)) - 1);
  endfunction

  function automatic logic [BTB_CTR_MAX_W-1:0] BTB_CTR_MAX(input int ctr_bits);
    return BTB_CTR_MAX_W'((1 << ctr_bits) - 1);
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational zero-latency lookup, one update per cycle on resolve.
// Never stalls; a same-cycle lookup of the index being updated sees the old entry.
module branch_target_buffer
  import cpu_types_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int CTR_BITS    = 2
) (
  input  logic  CLK,
  input  logic  nRST,
  input  word_t i_lookup_pc,
  output logic  o_hit,
  output logic  o_taken,
  output word_t o_target,
  input  logic  i_upd_vld,
  input  logic  i_upd_is_branch,
  input  logic  i_upd_taken,
  input  word_t i_upd_pc,
  input  word_t i_upd_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam logic [BTB_CTR_MAX_W-1:0] CTR_MAX = BTB_CTR_MAX(CTR_BITS);
  localparam logic [BTB_CTR_MAX_W-1:0] CTR_WT  = BTB_CTR_WEAK_T(CTR_BITS);
  localparam logic [BTB_CTR_MAX_W-1:0] CTR_WNT = BTB_CTR_WEAK_NT(CTR_BITS);

  btb_entry_t r_btb [BTB_ENTRIES];

  logic [IDX_W-1:0]         w_lidx;
  logic [IDX_W-1:0]         w_uidx;
  logic [BTB_TAG_MAX_W-1:0] w_ltag;
  logic [BTB_TAG_MAX_W-1:0] w_utag;
  btb_entry_t               w_lent;
  btb_entry_t               w_uent;
  btb_entry_t               w_new;
  logic                     w_uhit;
  logic                     w_wr;

  assign w_lidx = i_lookup_pc[IDX_W+1:2];
  assign w_uidx = i_upd_pc[IDX_W+1:2];
  assign w_ltag = BTB_TAG_MAX_W'(i_lookup_pc >> (IDX_W + 2));
  assign w_utag = BTB_TAG_MAX_W'(i_upd_pc >> (IDX_W + 2));
  assign w_lent = r_btb[w_lidx];
  assign w_uent = r_btb[w_uidx];

  assign o_hit    = w_lent.valid && (w_lent.tag == w_ltag);
  assign o_taken  = o_hit && w_lent.counter[CTR_BITS-1];
  assign o_target = w_lent.target;

  assign w_uhit = w_uent.valid && (w_uent.tag == w_utag);

  always_comb begin
    w_new = w_uent;
    w_wr  = 1'b0;
    if (i_upd_vld) begin
      if (w_uhit) begin
        w_wr = 1'b1;
        if (i_upd_is_branch) begin
          if (i_upd_taken) begin
            w_new.target = i_upd_target;
            if (w_uent.counter != CTR_MAX) w_new.counter = w_uent.counter + 1'b1;
          end else if (w_uent.counter != '0) begin
            w_new.counter = w_uent.counter - 1'b1;
          end
        end else begin
          w_new.counter = CTR_MAX;
          w_new.target  = i_upd_target;
        end
      end else if (i_upd_taken) begin
        // Allocate (evicting any alias); not-taken misses leave the entry alone.
        w_wr          = 1'b1;
        w_new.valid   = 1'b1;
        w_new.tag     = w_utag;
        w_new.target  = i_upd_target;
        w_new.counter = i_upd_is_branch ? CTR_WT : CTR_MAX;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btb[i] <= '{valid: 1'b0, tag: '0, target: '0, counter: CTR_WNT};
      end
    end else if (w_wr) begin
      r_btb[w_uidx] <= w_new;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC register, BTB next-PC prediction, mispredict redirect; zero-latency prediction.
// PC advances only on ihit && !stall && !halt; stalled redirects are held pending. Stats need BTB_STATS_EN.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT     = 32'h0,
  parameter int    BTB_ENTRIES = 16,
  parameter int    CTR_BITS    = 2
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ihit,
  input  logic  stall,
  input  logic  halt,
  output logic  imemREN,
  output word_t imemaddr,
  output word_t npc,
  output logic  pred_taken,
  output word_t pred_target,
  input  logic  resolve_valid,
  input  word_t resolve_pc,
  input  logic  resolve_is_branch,
  input  logic  resolve_taken,
  input  word_t resolve_target,
  input  logic  resolve_pred_taken,
  input  word_t resolve_pred_target,
  output logic  mispredict,
  output word_t stat_lookups,
  output word_t stat_hits,
  output word_t stat_mispredicts
);

  word_t r_pc;
  logic  r_pend_vld;
  word_t r_pend_addr;
  logic  r_halt;

  logic  w_hit;
  logic  w_btb_taken;
  word_t w_btb_target;
  logic  w_update;
  word_t w_correct_pc;
  word_t w_next_pc;

  branch_target_buffer #(
    .BTB_ENTRIES (BTB_ENTRIES),
    .CTR_BITS    (CTR_BITS)
  ) u_btb (
    .CLK             (CLK),
    .nRST            (nRST),
    .i_lookup_pc     (r_pc),
    .o_hit           (w_hit),
    .o_taken         (w_btb_taken),
    .o_target        (w_btb_target),
    .i_upd_vld       (resolve_valid),
    .i_upd_is_branch (resolve_is_branch),
    .i_upd_taken     (resolve_taken),
    .i_upd_pc        (resolve_pc),
    .i_upd_target    (resolve_target)
  );

  assign imemaddr    = r_pc;
  assign npc         = r_pc + 32'd4;
  assign imemREN     = !r_halt;
  assign pred_taken  = w_btb_taken;
  assign pred_target = w_btb_taken ? w_btb_target : npc;

  assign mispredict = resolve_valid &&
                      ((resolve_taken != resolve_pred_taken) ||
                       (resolve_taken && (resolve_target != resolve_pred_target)));
  assign w_correct_pc = resolve_taken ? resolve_target : (resolve_pc + 32'd4);
  assign w_update     = ihit && !stall && !r_halt;

  always_comb begin
    w_next_pc = pred_target;
    if (mispredict)      w_next_pc = w_correct_pc;
    else if (r_pend_vld) w_next_pc = r_pend_addr;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pc        <= PC_INIT;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_halt      <= 1'b0;
    end else begin
      r_halt <= r_halt | halt;
      if (w_update) begin
        r_pc       <= w_next_pc;
        r_pend_vld <= 1'b0;
      end else if (mispredict) begin
        // Newest redirect wins; older pending address is dropped.
        r_pend_vld  <= 1'b1;
        r_pend_addr <= w_correct_pc;
      end
    end
  end

`ifdef BTB_STATS_EN
  word_t r_stat_lookups;
  word_t r_stat_hits;
  word_t r_stat_mispredicts;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stat_lookups     <= '0;
      r_stat_hits        <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_update && (r_stat_lookups != '1))          r_stat_lookups     <= r_stat_lookups + 32'd1;
      if (w_update && w_hit && (r_stat_hits != '1))    r_stat_hits        <= r_stat_hits + 32'd1;
      if (mispredict && (r_stat_mispredicts != '1))    r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_lookups     = r_stat_lookups;
  assign stat_hits        = r_stat_hits;
  assign stat_mispredicts = r_stat_mispredicts;
`else
  assign stat_lookups     = '0;
  assign stat_hits        = '0;
  assign stat_mispredicts = '0;
`endif

endmodule
